// File: rtl/rdn_popcount_seq.sv
// rdn_popcount_seq: sequential ones-counter, CHUNK bits per cycle over a WIDTH-bit word.
// Latency: result valid STEPS cycles after the input handshake; a new word can load on the pop cycle.
// Backpressure: result held stable until out_ready; in_ready low while busy or result pending.
// Build option RDN_THRESHOLD_EN adds the thresh input and the out_ge compare flag.
module rdn_popcount_seq #(
    parameter int  WIDTH = 8,
    parameter int  CHUNK = 2,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int STEPS = (WIDTH + CHUNK - 1) / CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_full,
    output logic             busy
`ifdef RDN_THRESHOLD_EN
    ,
    input  logic [CW-1:0]    thresh,
    output logic             out_ge
`endif
);

    localparam int SW  = STEPS * CHUNK;
    localparam int SCW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SCW-1:0] LAST_STEP = SCW'(STEPS - 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    logic [SW-1:0]  shreg;
    logic [CW-1:0]  acc;
    logic [SCW-1:0] step;
    logic [CW-1:0]  chunk_cnt;
    logic [CW-1:0]  acc_next;
    logic           accept;
`ifdef RDN_THRESHOLD_EN
    logic [CW-1:0]  thresh_q;
`endif

    // Pad bits above WIDTH are zero, so the final partial chunk adds nothing spurious.
    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_cnt = chunk_cnt + CW'(shreg[i]);
        end
        acc_next = acc + chunk_cnt;
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_full  <= 1'b0;
            busy      <= 1'b0;
`ifdef RDN_THRESHOLD_EN
            thresh_q  <= '0;
            out_ge    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: ;
                BUSY: begin
                    acc   <= acc_next;
                    shreg <= shreg >> CHUNK;
                    step  <= step + SCW'(1);
                    if (step == LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_count <= acc_next;
                        out_full  <= (acc_next == FULL_CNT);
`ifdef RDN_THRESHOLD_EN
                        out_ge    <= (acc_next >= thresh_q);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A load overrides the DONE->IDLE move so a popped result chains straight into BUSY.
            if (accept) begin
                shreg <= SW'(in_data);
                acc   <= '0;
                step  <= '0;
                busy  <= 1'b1;
                state <= BUSY;
`ifdef RDN_THRESHOLD_EN
                thresh_q <= thresh;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rdn_popcount_seq.sv
// Bench for rdn_popcount_seq: WIDTH=8/CHUNK=2 and WIDTH=5/CHUNK=2 instances, transaction-level model plus literal checks.
module tb_rdn_popcount_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_full, a_busy;
    logic [7:0] a_in_data;
    logic [3:0] a_out_count;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_full, b_busy;
    logic [4:0] b_in_data;
    logic [2:0] b_out_count;
`ifdef RDN_THRESHOLD_EN
    logic [3:0] a_thresh;
    logic       a_out_ge;
    logic [2:0] b_thresh;
    logic       b_out_ge;
`endif

    rdn_popcount_seq #(.WIDTH(8), .CHUNK(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_count(a_out_count), .out_full(a_out_full), .busy(a_busy)
`ifdef RDN_THRESHOLD_EN
        , .thresh(a_thresh), .out_ge(a_out_ge)
`endif
    );

    rdn_popcount_seq #(.WIDTH(5), .CHUNK(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_count(b_out_count), .out_full(b_out_full), .busy(b_busy)
`ifdef RDN_THRESHOLD_EN
        , .thresh(b_thresh), .out_ge(b_out_ge)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit m_have[2];
    int m_cnt[2];
    int m_at[2];
    int m_th[2];
    int rd53[32] = '{0,1,1,2,1,2,2,3, 1,2,2,3,2,3,3,4, 1,2,2,3,2,3,3,4, 2,3,3,4,3,4,4,5};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction view: at most one word in flight; its result shows STEPS edges after the accept edge.
    task automatic model_step(input int id, input int width, input int steps,
                              input int iv, input int ir, input int d,
                              input int ov, input int orr, input int cnt,
                              input int full, input int bsy, input int th, input int ge);
        string p = (id == 0) ? "a" : "b";
        bit ev, eb, er;
        ev = m_have[id] && (cyc >= m_at[id]);
        eb = m_have[id] && (cyc < m_at[id]);
        er = !m_have[id] || (ev && orr != 0);
        chk($sformatf("%s.out_valid", p), ov, int'(ev));
        chk($sformatf("%s.busy", p), bsy, int'(eb));
        chk($sformatf("%s.in_ready", p), ir, int'(er));
        if (ev) begin
            chk($sformatf("%s.out_count", p), cnt, m_cnt[id]);
            chk($sformatf("%s.out_full", p), full, int'(m_cnt[id] == width));
`ifdef RDN_THRESHOLD_EN
            chk($sformatf("%s.out_ge", p), ge, int'(m_cnt[id] >= m_th[id]));
`endif
        end
        if (ev && orr != 0) m_have[id] = 1'b0;
        if (iv != 0 && er) begin
            m_have[id] = 1'b1;
            m_cnt[id]  = $countones(d);
            m_at[id]   = cyc + 1 + steps;
            m_th[id]   = th;
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a.accept_timeout", int'(n < 50), 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = 8'h5A;
    endtask

    task automatic send_b(input logic [4:0] d);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(negedge clk);
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b.accept_timeout", int'(n < 50), 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = 5'h15;
    endtask

    task automatic run_a(input logic [7:0] d, input int cnt, input int full, input int ge);
        send_a(d);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("a.lit_busy", a_busy, 1);
            chk("a.lit_early_valid", a_out_valid, 0);
        end
        @(negedge clk);
        chk("a.lit_valid", a_out_valid, 1);
        chk("a.lit_count", a_out_count, cnt);
        chk("a.lit_full", a_out_full, full);
`ifdef RDN_THRESHOLD_EN
        chk("a.lit_ge", a_out_ge, ge);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic run_b(input logic [4:0] d, input int cnt, input int full);
        send_b(d);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b.lit_busy", b_busy, 1);
        end
        @(negedge clk);
        chk("b.lit_valid", b_out_valid, 1);
        chk("b.lit_count", b_out_count, cnt);
        chk("b.lit_full", b_out_full, full);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
`ifdef RDN_THRESHOLD_EN
        a_thresh = '0;
        b_thresh = '0;
`endif
        fork
            forever begin
                @(negedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_have[0] = 1'b0;
                    m_have[1] = 1'b0;
                end else begin
                    cyc++;
`ifdef RDN_THRESHOLD_EN
                    model_step(0, 8, 4, a_in_valid, a_in_ready, a_in_data, a_out_valid, a_out_ready,
                               a_out_count, a_out_full, a_busy, a_thresh, a_out_ge);
                    model_step(1, 5, 3, b_in_valid, b_in_ready, b_in_data, b_out_valid, b_out_ready,
                               b_out_count, b_out_full, b_busy, b_thresh, b_out_ge);
`else
                    model_step(0, 8, 4, a_in_valid, a_in_ready, a_in_data, a_out_valid, a_out_ready,
                               a_out_count, a_out_full, a_busy, 0, 0);
                    model_step(1, 5, 3, b_in_valid, b_in_ready, b_in_data, b_out_valid, b_out_ready,
                               b_out_count, b_out_full, b_busy, 0, 0);
`endif
                end
            end
        join_none

        #12;
        chk("rst.a_in_ready", a_in_ready, 1);
        chk("rst.a_out_valid", a_out_valid, 0);
        chk("rst.a_out_count", a_out_count, 0);
        chk("rst.a_out_full", a_out_full, 0);
        chk("rst.a_busy", a_busy, 0);
        chk("rst.b_in_ready", b_in_ready, 1);
        chk("rst.b_out_valid", b_out_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_a(8'b1011_0110, 5, 0, 1);
        run_a(8'hFF, 8, 1, 1);
        run_a(8'h00, 0, 0, 1);

        // Held result under back-pressure, then same-cycle pop and accept.
        a_out_ready = 1'b0;
        send_a(8'h33);
        n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a.hold_timeout", int'(n < 50), 1);
        for (int i = 0; i < 3; i++) begin
            chk("a.hold_count", a_out_count, 4);
            chk("a.hold_valid", a_out_valid, 1);
            chk("a.hold_in_ready", a_in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h0F;
        @(negedge clk);
        chk("a.pop_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("a.chain_busy", a_busy, 1);
            chk("a.chain_valid", a_out_valid, 0);
        end
        @(negedge clk);
        chk("a.chain_valid_hi", a_out_valid, 1);
        chk("a.chain_count", a_out_count, 4);
        @(posedge clk);
        #1;

        // Abort mid-BUSY: asynchronous reset after the second step.
        send_a(8'hAB);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.a_out_valid", a_out_valid, 0);
        chk("abort.a_busy", a_busy, 0);
        chk("abort.a_in_ready", a_in_ready, 1);
        chk("abort.a_out_count", a_out_count, 0);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort.no_result", a_out_valid, 0);
        end
        @(posedge clk);
        #1;

        for (int d = 0; d < 32; d++) begin
            run_b(5'(d), rd53[d], int'(d == 31));
        end

`ifdef RDN_THRESHOLD_EN
        a_thresh = 4'd4;
        run_a(8'h0F, 4, 0, 1);
        run_a(8'h07, 3, 0, 0);
        a_thresh = 4'd0;
        run_a(8'h00, 0, 0, 1);
        run_a(8'h01, 1, 0, 1);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
